// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-client memory port arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking
// (default build uses fixed priority with the D-side winning ties).
package mem_port_arbiter_pkg;

    // Default data/address width of the merged port
    localparam int unsigned ARB_DEFAULT_WIDTH = 32;

    // Arbiter FSM states: idle, I-side granted, D-side granted
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Client identifiers
    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_client_t;

    // A client is requesting whenever it raises either strobe
    function automatic logic client_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

    // The client that did not win last time
    function automatic arb_client_t other_client(input arb_client_t c);
        return (c == ARB_I) ? ARB_D : ARB_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Combinational grant selector for the two memory clients.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking based on
// last_grant; without it the D-side always wins a tie.
module mem_port_arbiter_grant_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic        i_req,
    input  logic        d_req,
    input  arb_client_t last_grant,
    output logic        grant_valid,
    output arb_client_t grant_client
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority does not need the grant history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winning client for the current cycle
    always_comb begin
        grant_valid  = i_req | d_req;
        grant_client = ARB_I;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_client = other_client(last_grant);
`else
            grant_client = ARB_D;
`endif
        end else if (d_req) begin
            grant_client = ARB_D;
        end else begin
            grant_client = ARB_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the I-fetch and LSQ memory ports onto one downstream port, one
// transaction at a time, routing the completion back to the granted client.
// Build option: ARB_ROUND_ROBIN_EN (round-robin ties instead of D-side priority).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned width = ARB_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [width/8-1:0]   i_mem_byte_enable,
    input  logic [width-1:0]     i_mem_address,
    input  logic [width-1:0]     i_mem_wdata,
    output logic                 i_mem_resp,
    output logic [width-1:0]     i_mem_rdata,

    input  logic                 lsq_mem_read,
    input  logic                 lsq_mem_write,
    input  logic [width/8-1:0]   lsq_mem_byte_enable,
    input  logic [width-1:0]     lsq_mem_address,
    input  logic [width-1:0]     lsq_mem_wdata,
    output logic                 lsq_mem_resp,
    output logic [width-1:0]     lsq_mem_rdata,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width/8-1:0]   mem_byte_enable,
    output logic [width-1:0]     mem_address,
    output logic [width-1:0]     mem_wdata,
    input  logic                 mem_resp,
    input  logic [width-1:0]     mem_rdata
);

    localparam int unsigned BE_W = width / 8;

    arb_state_t   state_q, state_d;
    arb_client_t  last_grant_q, last_grant_d;
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic [BE_W-1:0]  mem_be_q, mem_be_d;
    logic [width-1:0] mem_addr_q, mem_addr_d;
    logic [width-1:0] mem_wdata_q, mem_wdata_d;

    logic             i_req_s;
    logic             d_req_s;
    logic             grant_valid_s;
    arb_client_t      grant_client_s;
    logic             sel_read_s;
    logic             sel_write_s;
    logic [BE_W-1:0]  sel_be_s;
    logic [width-1:0] sel_addr_s;
    logic [width-1:0] sel_wdata_s;

    assign i_req_s = client_req(i_mem_read, i_mem_write);
    assign d_req_s = client_req(lsq_mem_read, lsq_mem_write);

    mem_port_arbiter_grant_sel u_grant_sel (
        .i_req        (i_req_s),
        .d_req        (d_req_s),
        .last_grant   (last_grant_q),
        .grant_valid  (grant_valid_s),
        .grant_client (grant_client_s)
    );

    // Mux the winning client's request fields toward the capture registers
    always_comb begin
        if (grant_client_s == ARB_D) begin
            sel_read_s  = lsq_mem_read;
            sel_write_s = lsq_mem_write;
            sel_be_s    = lsq_mem_byte_enable;
            sel_addr_s  = lsq_mem_address;
            sel_wdata_s = lsq_mem_wdata;
        end else begin
            sel_read_s  = i_mem_read;
            sel_write_s = i_mem_write;
            sel_be_s    = i_mem_byte_enable;
            sel_addr_s  = i_mem_address;
            sel_wdata_s = i_mem_wdata;
        end
    end

    // FSM next state, request capture and strobe release
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    // A simultaneous read and write is issued as a write
                    mem_write_d = sel_write_s;
                    mem_read_d  = sel_read_s & ~sel_write_s;
                    mem_be_d    = sel_be_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    state_d     = (grant_client_s == ARB_D) ? GNT_D : GNT_I;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_resp) begin
                    // Drop strobes for one idle bubble before the next grant
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = IDLE;
                    last_grant_d = (state_q == GNT_D) ? ARB_D : ARB_I;
                end else begin
                    // Hold the captured copy; client inputs are ignored here
                    state_d = state_q;
                end
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and capture registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= {BE_W{1'b0}};
            mem_addr_q   <= {width{1'b0}};
            mem_wdata_q  <= {width{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Route the downstream completion to the granted client only
    always_comb begin
        i_mem_resp    = 1'b0;
        lsq_mem_resp  = 1'b0;
        i_mem_rdata   = {width{1'b0}};
        lsq_mem_rdata = {width{1'b0}};
        if (mem_resp) begin
            case (state_q)
                GNT_I: begin
                    i_mem_resp  = 1'b1;
                    i_mem_rdata = mem_rdata;
                end
                GNT_D: begin
                    lsq_mem_resp  = 1'b1;
                    lsq_mem_rdata = mem_rdata;
                end
                default: begin
                    // A completion with nothing in flight is dropped
                    i_mem_resp   = 1'b0;
                    lsq_mem_resp = 1'b0;
                end
            endcase
        end else begin
            i_mem_resp   = 1'b0;
            lsq_mem_resp = 1'b0;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_address     = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Expectations follow the
// ARB_ROUND_ROBIN_EN build option when it is defined.
module tb_mem_port_arbiter;

    typedef struct {
        int          client;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } req_t;

    typedef struct {
        int          client;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [3:0]  i_mem_byte_enable = 4'h0;
    logic [31:0] i_mem_address = 32'h0, i_mem_wdata = 32'h0;
    logic        i_mem_resp;
    logic [31:0] i_mem_rdata;
    logic        lsq_mem_read = 1'b0, lsq_mem_write = 1'b0;
    logic [3:0]  lsq_mem_byte_enable = 4'h0;
    logic [31:0] lsq_mem_address = 32'h0, lsq_mem_wdata = 32'h0;
    logic        lsq_mem_resp;
    logic [31:0] lsq_mem_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    logic        model_resp = 1'b0;
    logic        inj_resp = 1'b0;
    logic [31:0] inj_rdata = 32'h0;
    int          lat = 3;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];

    logic        op_rd    [0:1][0:15];
    logic        op_wr    [0:1][0:15];
    logic [31:0] op_addr  [0:1][0:15];
    logic [31:0] op_wdata [0:1][0:15];
    logic [3:0]  op_be    [0:1][0:15];
    int          n_ops    [0:1];

    // Memory contents seen by reads
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h60) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    assign mem_resp  = model_resp | inj_resp;
    assign mem_rdata = inj_resp ? inj_rdata : (model_resp ? rdata_of(mem_address) : 32'h5A5A_5A5A);

    mem_port_arbiter #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_byte_enable(i_mem_byte_enable), .i_mem_address(i_mem_address),
        .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
        .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
        .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp), .lsq_mem_rdata(lsq_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    // Clock generation
    initial forever #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int c, input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input int at);
        req_t r;
        r.client = c; r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d; r.be = b; r.cyc = at;
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input int c, input logic [31:0] rd);
        rsp_t r;
        r.client = c; r.rdata = rd;
        exp_rsp_q.push_back(r);
    endtask

    task automatic set_op(input int c, input int k, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        op_rd[c][k] = rd; op_wr[c][k] = wr; op_addr[c][k] = a; op_wdata[c][k] = d; op_be[c][k] = b;
    endtask

    task automatic drive(input int c, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (c == 0) begin
            i_mem_read = rd; i_mem_write = wr; i_mem_address = a; i_mem_wdata = d; i_mem_byte_enable = b;
        end else begin
            lsq_mem_read = rd; lsq_mem_write = wr; lsq_mem_address = a; lsq_mem_wdata = d; lsq_mem_byte_enable = b;
        end
    endtask

    // Client sequencer: holds each request until its resp, then presents the next one at once
    task automatic run_client(input int c);
        int   budget;
        logic got;
        for (int k = 0; k < n_ops[c]; k++) begin
            drive(c, op_rd[c][k], op_wr[c][k], op_addr[c][k], op_wdata[c][k], op_be[c][k]);
            budget = 0;
            got    = 1'b0;
            while (!got && budget < 200) begin
                @(negedge clk);
                budget++;
                got = (c == 0) ? i_mem_resp : lsq_mem_resp;
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL client%0d_timeout: got no resp, want resp within 200 cycles", c);
            end
            @(posedge clk); #1;
        end
        drive(c, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Downstream memory model: completes each access after lat cycles
    initial begin
        int mcnt = 0;
        bit served = 1'b0;
        forever begin
            @(posedge clk); #1;
            model_resp = 1'b0;
            if (!rst || !(mem_read || mem_write)) begin
                mcnt = 0; served = 1'b0;
            end else if (!served) begin
                mcnt++;
                if (mcnt == lat) begin
                    model_resp = 1'b1;
                    served     = 1'b1;
                end
            end
        end
    end

    req_t cur;
    bit   active = 1'b0;
    bit   prev_resp = 1'b0;

    // Monitor: compares DUT outputs against the scoreboard on every falling edge
    always @(negedge clk) begin
        logic exp_i, exp_d;
        rsp_t r;
        if (!rst) begin
            check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
            check("rst_addr", mem_address, 32'h0);
            check("rst_wdata", mem_wdata, 32'h0);
            check("rst_be", {28'h0, mem_byte_enable}, 32'h0);
            check("rst_resp", {30'h0, i_mem_resp, lsq_mem_resp}, 32'h0);
            check("rst_rdata", i_mem_rdata | lsq_mem_rdata, 32'h0);
            active = 1'b0; prev_resp = 1'b0;
        end else begin
            if (prev_resp)
                check("strobe_clear", {30'h0, mem_read, mem_write}, 32'h0);
            if ((mem_read || mem_write) && !active) begin
                if (exp_req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr %h rd %b wr %b, want no request", mem_address, mem_read, mem_write);
                    cur.client = -1; cur.rd = mem_read; cur.wr = mem_write; cur.addr = mem_address;
                    cur.wdata = mem_wdata; cur.be = mem_byte_enable; cur.cyc = -1;
                end else begin
                    cur = exp_req_q.pop_front();
                    check("req_read", {31'h0, mem_read}, {31'h0, cur.rd});
                    check("req_write", {31'h0, mem_write}, {31'h0, cur.wr});
                    check("req_addr", mem_address, cur.addr);
                    check("req_wdata", mem_wdata, cur.wdata);
                    check("req_be", {28'h0, mem_byte_enable}, {28'h0, cur.be});
                    if (cur.cyc >= 0) check("req_latency", cyc, cur.cyc);
                end
                active = 1'b1;
            end else if (active) begin
                check("hold_strobes", {30'h0, mem_read, mem_write}, {30'h0, cur.rd, cur.wr});
                check("hold_addr", mem_address, cur.addr);
                check("hold_wdata", mem_wdata, cur.wdata);
                check("hold_be", {28'h0, mem_byte_enable}, {28'h0, cur.be});
            end
            exp_i = active && mem_resp && (cur.client == 0);
            exp_d = active && mem_resp && (cur.client == 1);
            check("i_resp", {31'h0, i_mem_resp}, {31'h0, exp_i});
            check("d_resp", {31'h0, lsq_mem_resp}, {31'h0, exp_d});
            check("i_rdata", i_mem_rdata, exp_i ? mem_rdata : 32'h0);
            check("d_rdata", lsq_mem_rdata, exp_d ? mem_rdata : 32'h0);
            if (i_mem_resp || lsq_mem_resp) begin
                if (exp_rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got i %b d %b, want no resp", i_mem_resp, lsq_mem_resp);
                end else begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_client", i_mem_resp ? 32'd0 : 32'd1, r.client);
                    check("rsp_rdata", i_mem_resp ? i_mem_rdata : lsq_mem_rdata, r.rdata);
                end
            end
            prev_resp = active && mem_resp;
            if (prev_resp) active = 1'b0;
        end
    end

    // Directed stimulus
    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        // Single I-side read of 0x60, memory answers in the third strobe cycle
        lat = 3;
        set_op(0, 0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
        n_ops[0] = 1; n_ops[1] = 0;
        push_req(0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, cyc + 1);
        push_rsp(0, 32'hDEAD_BEEF);
        fork run_client(0); run_client(1); join
        idle(3);

        // D-side partial write
        set_op(1, 0, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 4'b0011);
        n_ops[0] = 0; n_ops[1] = 1;
        push_req(1, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, cyc + 1);
        push_rsp(1, 32'hA5A5_0100);
        fork run_client(0); run_client(1); join
        idle(3);

        // Tie in the same cycle, last grant was D
        set_op(0, 0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        set_op(1, 0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        n_ops[0] = 1; n_ops[1] = 1;
`ifdef ARB_ROUND_ROBIN_EN
        push_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, cyc + 1); push_rsp(0, 32'hA5A5_0300);
        push_req(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, cyc + 5); push_rsp(1, 32'hA5A5_0400);
`else
        push_req(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, cyc + 1); push_rsp(1, 32'hA5A5_0400);
        push_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, cyc + 5); push_rsp(0, 32'hA5A5_0300);
`endif
        fork run_client(0); run_client(1); join
        idle(3);

        // Continuous contention, five transactions per client
        for (int k = 0; k < 5; k++) begin
            set_op(0, k, 1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'hF);
            set_op(1, k, 1'b0, 1'b1, 32'h2000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'hF);
        end
        n_ops[0] = 5; n_ops[1] = 5;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 5; k++) begin
            push_req(0, 1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'hF, (k == 0) ? cyc + 1 : -1);
            push_rsp(0, rdata_of(32'h1000 + 32'(4 * k)));
            push_req(1, 1'b0, 1'b1, 32'h2000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'hF, -1);
            push_rsp(1, rdata_of(32'h2000 + 32'(4 * k)));
        end
`else
        for (int k = 0; k < 5; k++) begin
            push_req(1, 1'b0, 1'b1, 32'h2000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'hF, (k == 0) ? cyc + 1 : -1);
            push_rsp(1, rdata_of(32'h2000 + 32'(4 * k)));
        end
        for (int k = 0; k < 5; k++) begin
            push_req(0, 1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'hF, -1);
            push_rsp(0, rdata_of(32'h1000 + 32'(4 * k)));
        end
`endif
        fork run_client(0); run_client(1); join
        idle(3);

        // Address change while granted must not reach the memory port
        set_op(0, 0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
        n_ops[0] = 1; n_ops[1] = 0;
        push_req(0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, cyc + 1);
        push_rsp(0, 32'hDEAD_BEEF);
        fork
            run_client(0);
            begin
                idle(2);
                i_mem_address = 32'h80;
            end
        join
        idle(3);

        // Read and write together on the I-side, single-cycle memory
        lat = 1;
        set_op(0, 0, 1'b1, 1'b1, 32'h500, 32'h77, 4'hC);
        n_ops[0] = 1; n_ops[1] = 0;
        push_req(0, 1'b0, 1'b1, 32'h500, 32'h77, 4'hC, cyc + 1);
        push_rsp(0, 32'hA5A5_0500);
        fork run_client(0); run_client(1); join
        idle(3);

        // Reset during a D-side access, then a stray completion in IDLE
        lat = 10;
        drive(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        push_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, cyc + 1);
        idle(2);
        #1 rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1 rst = 1'b1;
        idle(1);
        inj_rdata = 32'hCAFE_F00D;
        inj_resp  = 1'b1;
        idle(1);
        inj_resp  = 1'b0;
        idle(3);

        // Normal operation after the reset
        lat = 2;
        set_op(1, 0, 1'b1, 1'b0, 32'h240, 32'h0, 4'hF);
        n_ops[0] = 0; n_ops[1] = 1;
        push_req(1, 1'b1, 1'b0, 32'h240, 32'h0, 4'hF, cyc + 1);
        push_rsp(1, 32'hA5A5_0240);
        fork run_client(0); run_client(1); join
        idle(5);

        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("rsp_queue_empty", exp_rsp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
